// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch target buffer.
//   ctr_t        : 2-bit bimodal counter encodings (SNT/WNT/WT/ST)
//   btb_entry_t  : one BTB entry (valid, tag, target, ctr, jump)
//   pc_tag       : extracts the tag field of a PC for a given index width
//   ctr_inc/dec  : saturating counter steps
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Wide enough for the smallest useful index (pc[31:2] with zero index bits).
  // Narrower tags are zero-extended into this field.
  localparam int TAG_W = 30;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_t             ctr;
    logic             jump;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: 32'h0,
    ctr:    CTR_WNT,
    jump:   1'b0
  };

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc,
                                              input int unsigned index_bits);
    logic [31:0] w_sh;
    w_sh = pc >> (index_bits + 2);
    return w_sh[TAG_W-1:0];
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// BTB storage: flop array of btb_entry_t with asynchronous reset.
// Ports:
//   clk, rst         : clock, async active-high reset (all entries cleared)
//   i_rd_idx         : fetch-side lookup index (combinational read)
//   o_rd_entry       : entry at i_rd_idx
//   i_upd_rd_idx     : update-side index, read to decide hit/allocate
//   o_upd_rd_entry   : entry at i_upd_rd_idx
//   i_wr_en/idx/entry: synchronous write port
// Reads always return the pre-edge contents: there is no write-to-read bypass.
module btb_array
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output btb_entry_t            o_rd_entry,
  input  logic [INDEX_BITS-1:0] i_upd_rd_idx,
  output btb_entry_t            o_upd_rd_entry,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  btb_entry_t            i_wr_entry
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  btb_entry_t r_mem [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= BTB_ENTRY_RESET;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

  assign o_rd_entry     = r_mem[i_rd_idx];
  assign o_upd_rd_entry = r_mem[i_upd_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit bimodal counters.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   if_pc                    : fetch PC; pred_taken/pred_target are combinational on it
//   upd_valid/is_jump/pc/taken/target/pred_taken/pred_target : resolved MEM-stage branch info
//   mispredict, correct_pc   : combinational redirect for the fetch PC mux
//   branch_count, mispredict_count : free-running 32-bit performance counters
// Handshake: upd_valid is a single-cycle qualifier with no back-pressure; every
// cycle it is high is exactly one committed update and one counted branch.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  btb_entry_t            w_if_entry;
  btb_entry_t            w_upd_entry;
  btb_entry_t            w_new_entry;
  logic                  w_if_hit;
  logic                  w_upd_hit;
  logic                  w_wr_en;
  logic [31:0]           r_branch_count;
  logic [31:0]           r_mispredict_count;
  logic                  w_unused;

  assign w_if_idx  = if_pc[INDEX_BITS+1:2];
  assign w_upd_idx = upd_pc[INDEX_BITS+1:2];
  assign w_unused  = ^{if_pc[1:0], upd_pc[1:0]};

  btb_array #(.INDEX_BITS(INDEX_BITS)) u_btb_array (
    .clk            (clk),
    .rst            (rst),
    .i_rd_idx       (w_if_idx),
    .o_rd_entry     (w_if_entry),
    .i_upd_rd_idx   (w_upd_idx),
    .o_upd_rd_entry (w_upd_entry),
    .i_wr_en        (w_wr_en),
    .i_wr_idx       (w_upd_idx),
    .i_wr_entry     (w_new_entry)
  );

  // Fetch-side lookup. Reset entries carry target 0, so pred_target is 0 in reset.
  assign w_if_hit    = w_if_entry.valid && (w_if_entry.tag == pc_tag(if_pc, INDEX_BITS));
  assign pred_taken  = w_if_hit && (w_if_entry.jump || w_if_entry.ctr[1]);
  assign pred_target = w_if_entry.target;

  assign w_upd_hit = w_upd_entry.valid && (w_upd_entry.tag == pc_tag(upd_pc, INDEX_BITS));

  // Update / allocate policy. A not-taken miss leaves the table untouched.
  always_comb begin
    w_new_entry = w_upd_entry;
    w_wr_en     = 1'b0;
    if (upd_valid) begin
      if (w_upd_hit) begin
        w_wr_en = 1'b1;
        if (upd_is_jump) begin
          w_new_entry.ctr    = CTR_ST;
          w_new_entry.jump   = 1'b1;
          w_new_entry.target = upd_target;
        end else if (upd_taken) begin
          w_new_entry.ctr    = ctr_inc(w_upd_entry.ctr);
          w_new_entry.target = upd_target;
        end else begin
          w_new_entry.ctr = ctr_dec(w_upd_entry.ctr);
        end
      end else if (upd_taken) begin
        w_wr_en            = 1'b1;
        w_new_entry.valid  = 1'b1;
        w_new_entry.tag    = pc_tag(upd_pc, INDEX_BITS);
        w_new_entry.target = upd_target;
        w_new_entry.jump   = upd_is_jump;
        w_new_entry.ctr    = upd_is_jump ? CTR_ST : CTR_WT;
      end
    end
  end

  // A taken outcome with a wrong target is a mispredict even if direction matched.
  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
  assign correct_pc = (upd_valid && upd_taken) ? upd_target : (upd_pc + 32'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else if (upd_valid) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic        upd_is_jump;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_is_jump      (upd_is_jump),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .correct_pc       (correct_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = one cycle. Outputs are checked before the edge that commits the
  // row's update, so predictions and counters reflect all earlier rows only.
  typedef struct {
    logic [31:0] if_pc;
    logic        uv;
    logic        uj;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mis;
    logic [31:0] e_cpc;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_pc           = v.if_pc;
    upd_valid       = v.uv;
    upd_is_jump     = v.uj;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("row%0d pred_taken", i),  {31'd0, pred_taken}, {31'd0, v.e_pt});
    if (v.e_pt)
      chk($sformatf("row%0d pred_target", i), pred_target, v.e_ptg);
    chk($sformatf("row%0d mispredict", i),  {31'd0, mispredict}, {31'd0, v.e_mis});
    chk($sformatf("row%0d correct_pc", i),  correct_pc, v.e_cpc);
    chk($sformatf("row%0d branch_count", i), branch_count, v.e_bc);
    chk($sformatf("row%0d mispredict_count", i), mispredict_count, v.e_mc);
  endtask

  initial begin
    //            if_pc   uv  uj  upc          ut  utgt    upt uptgt   | pt  ptg     mis cpc     bc     mc
    vecs[0]  = '{32'h60,  1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,   32'd0, 32'd0};
    vecs[0].uv = 1'b0;
    // taken branch allocates; same-cycle lookup still misses
    vecs[1]  = '{32'h60,  1, 0, 32'h60,       1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100, 32'd0, 32'd0};
    // now predicted taken (ctr 10); resolve not taken -> ctr 01
    vecs[2]  = '{32'h60,  1, 0, 32'h60,       0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h64,  32'd1, 32'd1};
    // predicted not taken; not taken again -> ctr 00
    vecs[3]  = '{32'h60,  1, 0, 32'h60,       0, 32'h0,   0, 32'h0,   0, 32'h100, 0, 32'h64,  32'd2, 32'd2};
    // taken from 00 -> 01, still not taken (proves counter reached 00)
    vecs[4]  = '{32'h60,  1, 0, 32'h60,       1, 32'h100, 0, 32'h0,   0, 32'h100, 1, 32'h100, 32'd3, 32'd2};
    vecs[5]  = '{32'h60,  0, 0, 32'h60,       0, 32'h0,   0, 32'h0,   0, 32'h100, 0, 32'h64,  32'd4, 32'd3};
    // jalr at 0x80 -> 0x200, then retargeted to 0x204
    vecs[6]  = '{32'h80,  1, 1, 32'h80,       1, 32'h200, 0, 32'h0,   0, 32'h0,   1, 32'h200, 32'd4, 32'd3};
    vecs[7]  = '{32'h80,  1, 1, 32'h80,       1, 32'h204, 1, 32'h200, 1, 32'h200, 1, 32'h204, 32'd5, 32'd4};
    vecs[8]  = '{32'h80,  1, 1, 32'h80,       1, 32'h204, 1, 32'h204, 1, 32'h204, 0, 32'h204, 32'd6, 32'd5};
    // 0x160 aliases 0x60 and replaces it
    vecs[9]  = '{32'h60,  1, 0, 32'h160,      1, 32'h300, 0, 32'h0,   0, 32'h100, 1, 32'h300, 32'd7, 32'd5};
    vecs[10] = '{32'h60,  0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h300, 0, 32'h4,   32'd8, 32'd6};
    vecs[11] = '{32'h160, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4,   32'd8, 32'd6};
    // same-index update and lookup: old prediction returned this cycle
    vecs[12] = '{32'h160, 1, 0, 32'h160,      0, 32'h0,   1, 32'h300, 1, 32'h300, 1, 32'h164, 32'd8, 32'd6};
    vecs[13] = '{32'h160, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h300, 0, 32'h4,   32'd9, 32'd7};
    // upd_valid low masks mispredict; pc+4 wraps to 0
    vecs[14] = '{32'h160, 0, 0, 32'hFFFFFFFC, 1, 32'h500, 0, 32'h0,   0, 32'h300, 0, 32'h0,   32'd9, 32'd7};

    rst = 1'b1;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    #1;
    chk("reset pred_taken",  {31'd0, pred_taken}, 32'd0);
    chk("reset pred_target", pred_target, 32'h0);
    chk("reset branch_count", branch_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Mid-stream reset: history discarded immediately, mispredict still follows inputs.
    @(negedge clk);
    if_pc     = 32'h80;
    upd_valid = 1'b0;
    #1;
    chk("pre-reset jump pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("pre-reset jump pred_target", pred_target, 32'h204);
    #1;
    rst             = 1'b1;
    upd_valid       = 1'b1;
    upd_is_jump     = 1'b0;
    upd_pc          = 32'h80;
    upd_taken       = 1'b1;
    upd_target      = 32'h40;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;
    #1;
    chk("in-reset pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("in-reset pred_target", pred_target, 32'h0);
    chk("in-reset branch_count", branch_count, 32'd0);
    chk("in-reset mispredict_count", mispredict_count, 32'd0);
    chk("in-reset mispredict", {31'd0, mispredict}, 32'd1);
    chk("in-reset correct_pc", correct_pc, 32'h40);
    @(negedge clk);
    rst       = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post-reset pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("post-reset branch_count", branch_count, 32'd0);
    chk("post-reset mispredict", {31'd0, mispredict}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
